// File: rtl/display_arbiter.sv
// ---------------------------------------------------------------------------
// display_arbiter
//   Shares one 4-digit display interface between NREQ requesters using
//   round-robin arbitration. Every grant lasts at least DWELL clk5 cycles so
//   the shown value stays readable. All outputs are registered.
//
// Ports
//   clk5       in   1         5 MHz system clock (only clock)
//   reset      in   1         asynchronous, active-low reset
//   req        in   NREQ      level-sensitive request per requester
//   req_val    in   16*NREQ   requester i value in [16*i+15:16*i]
//   req_point  in   4*NREQ    requester i point markers in [4*i+3:4*i]
//   grant      out  NREQ      one-hot current owner, zero while idle
//   owner      out  2         index of current or most recent owner
//   busy       out  1         high while a requester owns the display
//   dispVal    out  16        registered value for the display interface
//   point      out  4         registered point markers for the display
// ---------------------------------------------------------------------------
module display_arbiter #(
  parameter int NREQ  = 4,
  parameter int DWELL = 5000000,
  parameter int CW    = 23
) (
  input  logic                 clk5,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   req_val,
  input  logic [4*NREQ-1:0]    req_point,
  output logic [NREQ-1:0]      grant,
  output logic [1:0]           owner,
  output logic                 busy,
  output logic [15:0]          dispVal,
  output logic [3:0]           point
);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t          r_state, w_stateNext;
  logic [NREQ-1:0] r_grant, w_grantNext;
  logic [1:0]      r_owner, w_ownerNext;
  logic            r_busy, w_busyNext;
  logic [15:0]     r_dispVal, w_dispValNext;
  logic [3:0]      r_point, w_pointNext;
  logic [CW-1:0]   r_cnt, w_cntNext;

  logic [1:0]      w_pick;
  logic [15:0]     w_pickVal;
  logic [3:0]      w_pickPt;
  logic            w_ownReq;
  logic [15:0]     w_ownVal;
  logic [3:0]      w_ownPt;
  logic            w_anyReq;

  assign w_anyReq = |req;

  // Round-robin pick: each requester gets a distance from the current owner
  // (owner+1 is 1, the owner itself is NREQ, i.e. scanned last); the closest
  // active requester wins. The owner's own lane is extracted here as well.
  always_comb begin : pickLogic
    int bestD;
    int d;
    bestD     = NREQ + 1;
    d         = 0;
    w_pick    = '0;
    w_pickVal = '0;
    w_pickPt  = '0;
    w_ownReq  = 1'b0;
    w_ownVal  = '0;
    w_ownPt   = '0;
    for (int i = 0; i < NREQ; i++) begin
      d = (i - int'(r_owner) + NREQ) % NREQ;
      if (d == 0) d = NREQ;
      if (req[i] && (d < bestD)) begin
        bestD     = d;
        w_pick    = 2'(i);
        w_pickVal = req_val[16*i +: 16];
        w_pickPt  = req_point[4*i +: 4];
      end
      if (i == int'(r_owner)) begin
        w_ownReq = req[i];
        w_ownVal = req_val[16*i +: 16];
        w_ownPt  = req_point[4*i +: 4];
      end
    end
  end

  // Next-state and next-output logic. A new grant (from IDLE or at dwell
  // expiry) always loads the picked requester and reloads the counter; the
  // counter is never allowed to wrap. At expiry the pick naturally prefers
  // other requesters and falls back to the owner, giving the re-grant case.
  always_comb begin
    w_stateNext   = r_state;
    w_grantNext   = r_grant;
    w_ownerNext   = r_owner;
    w_busyNext    = r_busy;
    w_dispValNext = r_dispVal;
    w_pointNext   = r_point;
    w_cntNext     = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_anyReq) begin
          w_stateNext   = SHOW;
          w_grantNext   = NREQ'(1) << w_pick;
          w_ownerNext   = w_pick;
          w_busyNext    = 1'b1;
          w_dispValNext = w_pickVal;
          w_pointNext   = w_pickPt;
          w_cntNext     = CW'(DWELL - 1);
        end
      end
      SHOW: begin
        if (r_cnt != '0) begin
          w_cntNext = r_cnt - CW'(1);
          // A dropped owner request freezes the display at its last value.
          if (w_ownReq) begin
            w_dispValNext = w_ownVal;
            w_pointNext   = w_ownPt;
          end
        end else if (w_anyReq) begin
          w_grantNext   = NREQ'(1) << w_pick;
          w_ownerNext   = w_pick;
          w_dispValNext = w_pickVal;
          w_pointNext   = w_pickPt;
          w_cntNext     = CW'(DWELL - 1);
        end else begin
          w_stateNext = IDLE;
          w_grantNext = '0;
          w_busyNext  = 1'b0;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // State and output registers; reset parks the round-robin pointer on the
  // last requester so the first grant after reset scans from requester 0.
  always_ff @(posedge clk5 or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_owner   <= 2'(NREQ - 1);
      r_busy    <= 1'b0;
      r_dispVal <= '0;
      r_point   <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_grant   <= w_grantNext;
      r_owner   <= w_ownerNext;
      r_busy    <= w_busyNext;
      r_dispVal <= w_dispValNext;
      r_point   <= w_pointNext;
      r_cnt     <= w_cntNext;
    end
  end

  assign grant   = r_grant;
  assign owner   = r_owner;
  assign busy    = r_busy;
  assign dispVal = r_dispVal;
  assign point   = r_point;

  // Structural invariants of the grant outputs.
  a_grantOneHot: assert property (@(posedge clk5) disable iff (!reset) $onehot0(grant));
  a_busyMatches: assert property (@(posedge clk5) disable iff (!reset) busy == (|grant));
  a_ownerRange:  assert property (@(posedge clk5) disable iff (!reset) int'(owner) < NREQ);

endmodule

// File: tb/tb_display_arbiter.sv
// ---------------------------------------------------------------------------
// tb_display_arbiter
//   Self-checking bench for display_arbiter with NREQ=4, DWELL=8. A
//   behavioural model tracks the owner and how long it has held the display;
//   the compare process checks every output on every falling clock edge.
//   Directed scenarios add literal expectations, then randomized traffic
//   (including asynchronous resets) runs against the model.
// ---------------------------------------------------------------------------
module tb_display_arbiter;

  localparam int NREQ  = 4;
  localparam int DWELL = 8;
  localparam int CW    = 4;

  logic                clk5;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [16*NREQ-1:0]  req_val;
  logic [4*NREQ-1:0]   req_point;
  logic [NREQ-1:0]     grant;
  logic [1:0]          owner;
  logic                busy;
  logic [15:0]         dispVal;
  logic [3:0]          point;

  int checks = 0;
  int errors = 0;

  display_arbiter #(.NREQ(NREQ), .DWELL(DWELL), .CW(CW)) dut (
    .clk5      (clk5),
    .reset     (reset),
    .req       (req),
    .req_val   (req_val),
    .req_point (req_point),
    .grant     (grant),
    .owner     (owner),
    .busy      (busy),
    .dispVal   (dispVal),
    .point     (point)
  );

  initial begin
    clk5 = 1'b0;
    forever #5 clk5 = ~clk5;
  end

  // Behavioural model: who owns the display, whether it is showing, and how
  // many cycles into the current grant we are.
  bit          mShow  = 1'b0;
  int          mOwner = NREQ - 1;
  int          mAge   = 0;
  logic [15:0] mVal   = '0;
  logic [3:0]  mPt    = '0;

  function automatic int rrPick(input logic [NREQ-1:0] r, input int from);
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (from + k) % NREQ;
      if (r[j]) return j;
    end
    return from;
  endfunction

  initial begin
    forever begin
      @(posedge clk5 or negedge reset);
      if (!reset) begin
        mShow  = 1'b0;
        mOwner = NREQ - 1;
        mAge   = 0;
        mVal   = '0;
        mPt    = '0;
      end else if (!mShow || (mAge == DWELL - 1)) begin
        if (req != '0) begin
          mOwner = rrPick(req, mOwner);
          mShow  = 1'b1;
          mAge   = 0;
          mVal   = req_val[16*mOwner +: 16];
          mPt    = req_point[4*mOwner +: 4];
        end else begin
          mShow = 1'b0;
        end
      end else begin
        mAge = mAge + 1;
        if (req[mOwner]) begin
          mVal = req_val[16*mOwner +: 16];
          mPt  = req_point[4*mOwner +: 4];
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge, all outputs against the model.
  initial begin
    logic [NREQ-1:0] expGrant;
    forever begin
      @(negedge clk5);
      expGrant = mShow ? (NREQ'(1) << mOwner) : '0;
      checkOutput("cmp_grant", 32'(grant), 32'(expGrant));
      checkOutput("cmp_owner", 32'(owner), 32'(mOwner));
      checkOutput("cmp_busy", 32'(busy), 32'(mShow));
      checkOutput("cmp_dispVal", 32'(dispVal), 32'(mVal));
      checkOutput("cmp_point", 32'(point), 32'(mPt));
    end
  end

  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [16*NREQ-1:0] v,
                               input logic [4*NREQ-1:0] p);
    req       = r;
    req_val   = v;
    req_point = p;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk5);
  endtask

  // Called just after a falling edge: asserts reset between edges and
  // releases it on the next falling edge with all requests low.
  task automatic pulseReset();
    #2 reset = 1'b0;
    req = '0;
    @(negedge clk5);
    reset = 1'b1;
  endtask

  localparam logic [16*NREQ-1:0] VALS = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
  localparam logic [4*NREQ-1:0]  PTS  = {4'h4, 4'h3, 4'h2, 4'h1};

  initial begin
    logic [NREQ-1:0] expG [5];
    logic [15:0]     expV [5];
    expG = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    expV = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h1111};

    // Reset held with every request active.
    reset = 1'b0;
    applyStimulus(4'b1111, VALS, PTS);
    waitCycles(2);
    checkOutput("rst_grant", 32'(grant), 32'h0);
    checkOutput("rst_owner", 32'(owner), 32'd3);
    checkOutput("rst_dispVal", 32'(dispVal), 32'h0);
    checkOutput("rst_point", 32'(point), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);

    // Round robin with all requests held: 8-cycle grants, no gaps.
    reset = 1'b1;
    waitCycles(1);
    checkOutput("rr_grant0", 32'(grant), 32'(expG[0]));
    checkOutput("rr_val0", 32'(dispVal), 32'(expV[0]));
    for (int g = 1; g < 5; g++) begin
      waitCycles(7);
      checkOutput("rr_hold", 32'(grant), 32'(expG[g-1]));
      waitCycles(1);
      checkOutput("rr_next", 32'(grant), 32'(expG[g]));
      checkOutput("rr_val", 32'(dispVal), 32'(expV[g]));
      checkOutput("rr_busy", 32'(busy), 32'h1);
    end

    // Single request with value tracking.
    pulseReset();
    applyStimulus(4'b0001, {48'h0, 16'h1234}, {12'h0, 4'h2});
    waitCycles(1);
    checkOutput("single_grant", 32'(grant), 32'h1);
    checkOutput("single_val", 32'(dispVal), 32'h1234);
    checkOutput("single_point", 32'(point), 32'h2);
    applyStimulus(4'b0001, {48'h0, 16'hABCD}, {12'h0, 4'h2});
    waitCycles(1);
    checkOutput("single_track", 32'(dispVal), 32'hABCD);

    // Early drop: grant held the full dwell with a frozen value.
    pulseReset();
    applyStimulus(4'b0001, {48'h0, 16'h00FF}, {12'h0, 4'h5});
    waitCycles(1);
    checkOutput("drop_grant", 32'(grant), 32'h1);
    waitCycles(1);
    applyStimulus(4'b0000, {48'h0, 16'h1111}, {12'h0, 4'h9});
    waitCycles(6);
    checkOutput("drop_hold", 32'(grant), 32'h1);
    checkOutput("drop_frozen", 32'(dispVal), 32'h00FF);
    waitCycles(1);
    checkOutput("drop_idle", 32'(grant), 32'h0);
    checkOutput("drop_busy", 32'(busy), 32'h0);
    checkOutput("drop_keepval", 32'(dispVal), 32'h00FF);
    checkOutput("drop_keepowner", 32'(owner), 32'd0);

    // Sole owner with a late arrival on requester 3.
    pulseReset();
    applyStimulus(4'b0010, VALS, PTS);
    waitCycles(1);
    checkOutput("late_grant1", 32'(grant), 32'h2);
    waitCycles(2);
    applyStimulus(4'b1010, VALS, PTS);
    waitCycles(5);
    checkOutput("late_hold1", 32'(grant), 32'h2);
    waitCycles(1);
    checkOutput("late_grant3", 32'(grant), 32'h8);
    checkOutput("late_owner3", 32'(owner), 32'd3);
    waitCycles(7);
    checkOutput("late_hold3", 32'(grant), 32'h8);
    waitCycles(1);
    checkOutput("late_back1", 32'(grant), 32'h2);

    // Asynchronous reset while showing owner 2 with four cycles left.
    pulseReset();
    applyStimulus(4'b0100, VALS, PTS);
    waitCycles(4);
    checkOutput("arst_before", 32'(grant), 32'h4);
    #2 reset = 1'b0;
    #1;
    checkOutput("arst_grant", 32'(grant), 32'h0);
    checkOutput("arst_owner", 32'(owner), 32'd3);
    checkOutput("arst_dispVal", 32'(dispVal), 32'h0);
    checkOutput("arst_busy", 32'(busy), 32'h0);
    @(negedge clk5);
    reset = 1'b1;
    applyStimulus(4'b1111, VALS, PTS);
    waitCycles(1);
    checkOutput("arst_restart", 32'(grant), 32'h1);

    // Randomized traffic against the model, with occasional async resets.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) req = NREQ'($urandom);
      if ($urandom_range(0, 1) == 0) req_val = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) req_point = 16'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b0;
        @(negedge clk5);
        reset = 1'b1;
      end else begin
        @(negedge clk5);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
